// File: rtl/uart_rx_fifo.sv
// RS-232 8-bit receiver (1+ stop bits) feeding a first-word-fall-through FIFO; push lands 1 clk after the stop midpoint tick.
// Output is valid/ready; a good byte arriving at a full FIFO with no same-cycle pop is dropped and flagged as overrun.
module uart_rx_fifo #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16,
  parameter int FifoDepth    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         RxD,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FifoDepth):0]   rx_count,
  output logic                         framing_error,
  output logic                         overrun,
  output logic                         rx_idle
);

  localparam int OsW  = $clog2(Oversampling);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int AccW = $clog2(ClkFrequency / (Baud * Oversampling)) + 8;
  localparam longint IncL = (((longint'(Baud) * longint'(Oversampling)) << AccW)
                             + longint'(ClkFrequency / 2)) / longint'(ClkFrequency);
  localparam logic [AccW:0]  Inc    = IncL[AccW:0];
  localparam logic [OsW-1:0] OsMid  = OsW'(Oversampling / 2);
  localparam logic [OsW-1:0] OsLast = OsW'(Oversampling - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_e;

  logic [AccW-1:0]  acc_q;
  logic [AccW:0]    acc_sum;
  logic             tick_q;
  logic [1:0]       sync_q;
  logic [2:0]       hist_q;
  logic             rxd_s;
  logic             maj;
  logic             mid;
  logic             wrap;

  state_e           state_q, state_d;
  logic [OsW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_q, push_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;

  logic [7:0]       mem_q [FifoDepth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr;

  // Carry out of the phase accumulator is the oversampling tick.
  assign acc_sum = {1'b0, acc_q} + Inc;
  assign rxd_s   = sync_q[1];
  assign maj     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign mid     = tick_q && (os_cnt_q == OsMid);
  assign wrap    = tick_q && (os_cnt_q == OsLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      acc_q  <= acc_sum[AccW-1:0];
      tick_q <= acc_sum[AccW];
      sync_q <= {sync_q[0], RxD};
      if (tick_q) hist_q <= {hist_q[1:0], rxd_s};
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = tick_q ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push_d    = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_q && !rxd_s) begin
          state_d  = ST_START;
          os_cnt_d = '0;
        end
      end
      ST_START: begin
        if (mid && maj) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (mid) shreg_d = {maj, shreg_q[7:1]};
        if (wrap) begin
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (mid) begin
          if (maj) begin
            push_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (tick_q && rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      push_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      push_q    <= push_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop   = rx_valid && rx_ready;
  // A pop frees the head slot this same edge, so a full FIFO can still accept.
  assign wr    = push_q && (!full || pop);
  assign ov_d  = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[PtrW-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rx_valid      = !empty;
  assign rx_data       = rx_valid ? mem_q[rptr_q[PtrW-1:0]] : 8'h00;
  assign rx_count      = wptr_q - rptr_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign rx_idle       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, delivered bytes checked against a queue model.
module tb_uart_rx_fifo;

  localparam int ClkHz  = 3686400;
  localparam int BaudR  = 115200;
  localparam int Os     = 16;
  localparam int Depth  = 8;
  localparam int BitClk = ClkHz / BaudR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       framing_error;
  logic       overrun;
  logic       rx_idle;

  int vec = 0;
  int errs = 0;

  // Model: bytes expected to be delivered, in order, plus expected pulse counts.
  logic [7:0] exp_q [$];
  logic [7:0] rcv_q [$];
  int         rcv_base = 0;
  int         exp_fe = 0;
  int         exp_ov = 0;

  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int cnt_max = 0;
  bit track = 1'b0;

  uart_rx_fifo #(
    .ClkFrequency(ClkHz),
    .Baud(BaudR),
    .Oversampling(Os),
    .FifoDepth(Depth)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RxD(RxD),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_count(rx_count),
    .framing_error(framing_error),
    .overrun(overrun),
    .rx_idle(rx_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (framing_error && overrun) both_cnt++;
    if (!track) cnt_max = 0;
    else if (int'(rx_count) > cnt_max) cnt_max = int'(rx_count);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int occupancy();
    return exp_q.size() - (rcv_q.size() - rcv_base);
  endfunction

  task automatic send_frame(input logic [7:0] b, input int nstop, input logic stopv);
    int occ_now;
    occ_now = occupancy();
    if (stopv) begin
      if (occ_now < Depth) exp_q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    RxD = 1'b0;
    wait_clks(BitClk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_clks(BitClk);
    end
    RxD = stopv;
    wait_clks(BitClk * nstop);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!rx_valid) break;
      rx_ready = 1'($urandom_range(0, 1));
      wait_clks(1);
    end
    rx_ready = 1'b0;
    wait_clks(1);
    chk("drain_empty", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic chk_queue(input string tag);
    int got;
    got = rcv_q.size() - rcv_base;
    chk({tag, "_len"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got) chk({tag, "_byte"}, {24'd0, rcv_q[rcv_base + i]}, {24'd0, exp_q[i]});
    end
    exp_q.delete();
    rcv_base = rcv_q.size();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  {24'd0, rx_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_count"}, {28'd0, rx_count}, 32'd0);
    chk({tag, "_fe"},    {31'd0, framing_error}, 32'd0);
    chk({tag, "_ov"},    {31'd0, overrun}, 32'd0);
    chk({tag, "_idle"},  {31'd0, rx_idle}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int         ns;

    // Reset state
    wait_clks(4);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clks(8);

    // Single 8N2 byte, held, then popped with a one-clock ready pulse
    send_frame(8'h55, 2, 1'b1);
    wait_clks(4);
    chk("t1_valid", {31'd0, rx_valid}, 32'd1);
    chk("t1_data",  {24'd0, rx_data}, {24'd0, exp_q[0]});
    chk("t1_count", {28'd0, rx_count}, occupancy());
    chk("t1_fe",    fe_cnt, exp_fe);
    chk("t1_ov",    ov_cnt, exp_ov);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(1);
    chk("t1_pop_valid", {31'd0, rx_valid}, 32'd0);
    chk("t1_pop_count", {28'd0, rx_count}, 32'd0);
    chk_queue("t1_q");

    // Random bytes with 1 or 2 stop bits, drained with a random ready pattern
    for (int k = 0; k < 4; k++) begin
      b  = 8'($urandom);
      ns = $urandom_range(1, 2);
      send_frame(b, ns, 1'b1);
    end
    wait_clks(4);
    chk("rand_count", {28'd0, rx_count}, occupancy());
    drain(200);
    chk_queue("rand_q");

    // Short low glitch is a false start
    RxD = 1'b0;
    wait_clks(8);
    RxD = 1'b1;
    wait_clks(BitClk);
    chk("glitch_idle",  {31'd0, rx_idle}, 32'd1);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_fe",    fe_cnt, exp_fe);

    // Bad stop bit followed by a held-low line
    send_frame(8'hA5, 1, 1'b0);
    wait_clks(3 * BitClk);
    chk("brk_fe",       fe_cnt, exp_fe);
    chk("brk_count",    {28'd0, rx_count}, occupancy());
    chk("brk_idle_low", {31'd0, rx_idle}, 32'd0);
    RxD = 1'b1;
    wait_clks(8);
    chk("brk_idle_high", {31'd0, rx_idle}, 32'd1);
    chk("brk_fe_after",  fe_cnt, exp_fe);

    // Nine back-to-back bytes into an 8-deep FIFO
    for (int k = 0; k < 9; k++) send_frame(8'(k), 1, 1'b1);
    wait_clks(4);
    chk("ovr_count", {28'd0, rx_count}, occupancy());
    chk("ovr_pulses", ov_cnt, exp_ov);
    chk("ovr_fe", fe_cnt, exp_fe);
    drain(200);
    chk_queue("ovr_q");

    // Streaming with the consumer always ready
    rx_ready = 1'b1;
    track = 1'b1;
    for (int k = 0; k < 256; k++) send_frame(8'(k), 1, 1'b1);
    wait_clks(8);
    chk("strm_max_count", {31'd0, (cnt_max <= 1)}, 32'd1);
    track = 1'b0;
    rx_ready = 1'b0;
    wait_clks(1);
    chk("strm_ov", ov_cnt, exp_ov);
    chk("strm_valid", {31'd0, rx_valid}, 32'd0);
    chk_queue("strm_q");

    // Reset during bit 4 of a frame while two bytes are queued
    send_frame(8'h11, 1, 1'b1);
    send_frame(8'h22, 1, 1'b1);
    wait_clks(4);
    chk("rst_pre_count", {28'd0, rx_count}, occupancy());
    b = 8'hF0 | 8'($urandom_range(0, 15));
    RxD = 1'b0;
    wait_clks(BitClk);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      wait_clks(BitClk);
    end
    RxD = b[4];
    wait_clks(10);
    rst_n = 1'b0;
    wait_clks(3);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    exp_q.delete();
    rcv_base = rcv_q.size();
    wait_clks(BitClk - 13);
    for (int i = 5; i < 8; i++) begin
      RxD = b[i];
      wait_clks(BitClk);
    end
    RxD = 1'b1;
    wait_clks(3 * BitClk);
    send_frame(8'h3C, 1, 1'b1);
    wait_clks(4);
    chk("post_valid", {31'd0, rx_valid}, 32'd1);
    chk("post_data",  {24'd0, rx_data}, {24'd0, exp_q[0]});
    chk("post_count", {28'd0, rx_count}, occupancy());
    chk("post_fe", fe_cnt, exp_fe);
    chk("post_ov", ov_cnt, exp_ov);
    drain(100);
    chk_queue("post_q");

    chk("fe_ov_overlap", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
